branch_ctrl: RTL and testbench

ID-stage branch sequencer for the 5-stage MIPS pipeline. It detects operand hazards for branch instructions sitting in ID and stalls IF/ID until operands can be forwarded. It drives the forwarding selects into the branch comparator, consumes the comparator's taken result, and issues the PC redirect (delay-slot semantics, so IF is never flushed). It also keeps 32-bit performance counters for branches, taken branches and branch stall cycles.

---
 rtl/branch_ctrl_if.sv | 43 ++++
 rtl/branch_ctrl.sv | 114 +++++++++++
 tb/tb_branch_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// Bundle between the ID-stage branch sequencer and the pipeline.
// It carries hazard/forwarding inputs, redirect/stall outputs and the perf counters.
interface branch_ctrl_if;
  logic        id_branch;
  logic        id_uses_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_target;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic [4:0]  ex_writereg;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [4:0]  mem_writereg;
  logic        flush;
  logic        cmp_taken;
  logic        stall;
  logic        fwd_a;
  logic        fwd_b;
  logic        redirect;
  logic [31:0] pc_target;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output id_branch, id_uses_rt, id_rs, id_rt, id_target,
           ex_regwrite, ex_memtoreg, ex_writereg,
           mem_regwrite, mem_memtoreg, mem_writereg,
           flush, cmp_taken,
    input  stall, fwd_a, fwd_b, redirect, pc_target,
           branch_cnt, taken_cnt, stall_cnt
  );

  modport slave (
    input  id_branch, id_uses_rt, id_rs, id_rt, id_target,
           ex_regwrite, ex_memtoreg, ex_writereg,
           mem_regwrite, mem_memtoreg, mem_writereg,
           flush, cmp_taken,
    output stall, fwd_a, fwd_b, redirect, pc_target,
           branch_cnt, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls on operand hazards, selects comparator
// forwarding, issues the delay-slot PC redirect and keeps perf counters.
module branch_ctrl (
  input  logic         clk,
  input  logic         rst,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        stall_c, resolve_c;
  logic [1:0]  haz_rs, haz_rt, haz;
  logic [31:0] branch_cnt_q, taken_cnt_q, stall_cnt_q;

  // Cycles a source register must wait: 2 behind an EX load, 1 behind an EX
  // ALU op or a MEM load. r0 is hardwired and never waits.
  function automatic logic [1:0] dep_cycles(
    input logic [4:0] r,
    input logic       ex_rw,  input logic ex_mtr,  input logic [4:0] ex_wr,
    input logic       mem_rw, input logic mem_mtr, input logic [4:0] mem_wr
  );
    logic ex_hit, mem_hit;
    ex_hit  = ex_rw  && (r != 5'd0) && (r == ex_wr);
    mem_hit = mem_rw && (r != 5'd0) && (r == mem_wr);
    if (ex_hit && ex_mtr)                 return 2'd2;
    else if (ex_hit || (mem_hit && mem_mtr)) return 2'd1;
    else                                  return 2'd0;
  endfunction

  always_comb begin
    haz_rs = dep_cycles(bus.id_rs, bus.ex_regwrite, bus.ex_memtoreg, bus.ex_writereg,
                        bus.mem_regwrite, bus.mem_memtoreg, bus.mem_writereg);
    haz_rt = bus.id_uses_rt
           ? dep_cycles(bus.id_rt, bus.ex_regwrite, bus.ex_memtoreg, bus.ex_writereg,
                        bus.mem_regwrite, bus.mem_memtoreg, bus.mem_writereg)
           : 2'd0;
    // Both operands wait in parallel, so the worse one sets the stall length.
    haz    = (haz_rs > haz_rt) ? haz_rs : haz_rt;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    stall_c   = 1'b0;
    resolve_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.id_branch) begin
          unique case (haz)
            2'd0:    resolve_c = 1'b1;
            2'd1:    begin stall_c = 1'b1; state_nx = RESOLVE; end
            default: begin stall_c = 1'b1; state_nx = STALL;   end
          endcase
        end
      end
      STALL: begin
        stall_c  = 1'b1;
        state_nx = RESOLVE;
      end
      RESOLVE: begin
        resolve_c = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      stall_c   = 1'b0;
      resolve_c = 1'b0;
      state_nx  = IDLE;
    end
  end

  // Outputs are held at their reset values while rst is high, so an
  // asynchronous reset drops stall without waiting for an edge.
  always_comb begin
    bus.stall     = stall_c & ~rst;
    bus.redirect  = resolve_c & bus.cmp_taken & ~rst;
    bus.pc_target = bus.redirect ? bus.id_target : 32'd0;
    bus.fwd_a     = ~rst & bus.mem_regwrite & ~bus.mem_memtoreg &
                    (bus.id_rs != 5'd0) & (bus.id_rs == bus.mem_writereg);
    bus.fwd_b     = ~rst & bus.mem_regwrite & ~bus.mem_memtoreg &
                    (bus.id_rt != 5'd0) & (bus.id_rt == bus.mem_writereg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      if (resolve_c)                 branch_cnt_q <= branch_cnt_q + 32'd1;
      if (resolve_c && bus.cmp_taken) taken_cnt_q  <= taken_cnt_q + 32'd1;
      if (stall_c)                   stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios then random traffic,
// all compared against a cycles-remaining model of branch resolution.
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_ctrl_if bi ();
  branch_ctrl dut (.clk(clk), .rst(rst), .bus(bi));

  int n_checks = 0;
  int n_err    = 0;

  // Model: cycles still owed by the branch currently held in ID.
  int          rem = 0;
  logic [31:0] m_branch = 0, m_taken = 0, m_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int wait_for(input logic [4:0] r);
    if (r == 0) return 0;
    if (bi.ex_regwrite && bi.ex_writereg == r) return bi.ex_memtoreg ? 2 : 1;
    if (bi.mem_regwrite && bi.mem_memtoreg && bi.mem_writereg == r) return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    bi.id_branch = 0; bi.id_uses_rt = 0; bi.id_rs = 0; bi.id_rt = 0;
    bi.id_target = 0; bi.ex_regwrite = 0; bi.ex_memtoreg = 0; bi.ex_writereg = 0;
    bi.mem_regwrite = 0; bi.mem_memtoreg = 0; bi.mem_writereg = 0;
    bi.flush = 0; bi.cmp_taken = 0;
  endtask

  // Called shortly after a rising edge with inputs already driven.
  task automatic cycle(input string tag);
    int   rem_n, h;
    logic e_stall, e_res, e_red;
    #4;
    rem_n = rem; e_stall = 0; e_res = 0;
    if (bi.flush) rem_n = 0;
    else if (rem > 0) begin
      rem_n = rem - 1;
      if (rem_n == 0) e_res = 1; else e_stall = 1;
    end else if (bi.id_branch) begin
      h = wait_for(bi.id_rs);
      if (bi.id_uses_rt && wait_for(bi.id_rt) > h) h = wait_for(bi.id_rt);
      if (h == 0) e_res = 1; else begin e_stall = 1; rem_n = h; end
    end
    e_red = e_res & bi.cmp_taken;
    check({tag, ".stall"},     32'(bi.stall),    32'(e_stall));
    check({tag, ".redirect"},  32'(bi.redirect), 32'(e_red));
    check({tag, ".pc_target"}, bi.pc_target,     e_red ? bi.id_target : 32'd0);
    check({tag, ".fwd_a"}, 32'(bi.fwd_a), 32'(bi.mem_regwrite && !bi.mem_memtoreg &&
                                             bi.id_rs != 0 && bi.id_rs == bi.mem_writereg));
    check({tag, ".fwd_b"}, 32'(bi.fwd_b), 32'(bi.mem_regwrite && !bi.mem_memtoreg &&
                                             bi.id_rt != 0 && bi.id_rt == bi.mem_writereg));
    @(posedge clk);
    rem = rem_n;
    if (e_res)              m_branch = m_branch + 1;
    if (e_res && bi.cmp_taken) m_taken = m_taken + 1;
    if (e_stall)            m_stall  = m_stall + 1;
    #1;
    check({tag, ".branch_cnt"}, bi.branch_cnt, m_branch);
    check({tag, ".taken_cnt"},  bi.taken_cnt,  m_taken);
    check({tag, ".stall_cnt"},  bi.stall_cnt,  m_stall);
  endtask

  initial begin
    clear_inputs();
    #3;
    check("reset.stall",      32'(bi.stall),    0);
    check("reset.redirect",   32'(bi.redirect), 0);
    check("reset.pc_target",  bi.pc_target,     0);
    check("reset.fwd",        {30'd0, bi.fwd_a, bi.fwd_b}, 0);
    check("reset.branch_cnt", bi.branch_cnt,    0);
    check("reset.stall_cnt",  bi.stall_cnt,     0);
    @(posedge clk); #1 rst = 0;

    // No hazard: BEQ r3,r4 taken.
    bi.id_branch = 1; bi.id_uses_rt = 1; bi.id_rs = 3; bi.id_rt = 4;
    bi.cmp_taken = 1; bi.id_target = 32'h0040_0020;
    cycle("nohaz");
    check("nohaz.branch_cnt_is1", bi.branch_cnt, 1);
    check("nohaz.taken_cnt_is1",  bi.taken_cnt,  1);

    // EX ALU hazard on rs=5, one stall, then forward from MEM.
    clear_inputs();
    bi.id_branch = 1; bi.id_uses_rt = 1; bi.id_rs = 5; bi.id_rt = 9;
    bi.ex_regwrite = 1; bi.ex_writereg = 5;
    cycle("exalu.s0");
    clear_inputs();
    bi.id_branch = 1; bi.id_uses_rt = 1; bi.id_rs = 5; bi.id_rt = 9;
    bi.mem_regwrite = 1; bi.mem_writereg = 5;
    #4 check("exalu.fwd_a_is1", 32'(bi.fwd_a), 1);
    #0 rem = rem; // keep timing aligned with cycle()'s internal delay below
    cycle("exalu.res");
    check("exalu.stall_cnt_is1", bi.stall_cnt, 1);

    // EX load hazard on rs=7 (BGTZ), two stalls.
    clear_inputs();
    bi.id_branch = 1; bi.id_rs = 7; bi.ex_regwrite = 1; bi.ex_memtoreg = 1; bi.ex_writereg = 7;
    cycle("exld.s0");
    clear_inputs();
    bi.id_branch = 1; bi.id_rs = 7; bi.mem_regwrite = 1; bi.mem_memtoreg = 1; bi.mem_writereg = 7;
    cycle("exld.s1");
    clear_inputs();
    bi.id_branch = 1; bi.id_rs = 7; bi.cmp_taken = 1; bi.id_target = 32'h0000_1234;
    cycle("exld.res");
    check("exld.stall_cnt_is3", bi.stall_cnt, 3);

    // rt ignored when unused; r0 never hazards.
    clear_inputs();
    bi.id_branch = 1; bi.id_rs = 2; bi.id_rt = 5; bi.ex_regwrite = 1; bi.ex_writereg = 5;
    cycle("rtfilter");
    clear_inputs();
    bi.id_branch = 1; bi.id_uses_rt = 1; bi.ex_regwrite = 1; bi.ex_memtoreg = 1;
    cycle("r0filter");

    // flush while in STALL.
    clear_inputs();
    bi.id_branch = 1; bi.id_rs = 6; bi.ex_regwrite = 1; bi.ex_memtoreg = 1; bi.ex_writereg = 6;
    cycle("flush.s0");
    bi.flush = 1; bi.cmp_taken = 1;
    cycle("flush.kill");
    clear_inputs();
    cycle("flush.idle");
    check("flush.branch_cnt_held", bi.branch_cnt, m_branch);

    // Asynchronous reset in the middle of STALL.
    bi.id_branch = 1; bi.id_rs = 6; bi.ex_regwrite = 1; bi.ex_memtoreg = 1; bi.ex_writereg = 6;
    cycle("rst.s0");
    #1 rst = 1;
    #1;
    check("rst.stall",      32'(bi.stall),    0);
    check("rst.redirect",   32'(bi.redirect), 0);
    check("rst.branch_cnt", bi.branch_cnt,    0);
    check("rst.stall_cnt",  bi.stall_cnt,     0);
    rem = 0; m_branch = 0; m_taken = 0; m_stall = 0;
    #1 rst = 0;
    clear_inputs();
    cycle("rst.idle");

    // stall_cnt wrap.
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFF;
    check("wrap.preload", bi.stall_cnt, 32'hFFFF_FFFF);
    bi.id_branch = 1; bi.id_rs = 8; bi.ex_regwrite = 1; bi.ex_writereg = 8;
    cycle("wrap.s0");
    check("wrap.stall_cnt_is0", bi.stall_cnt, 0);
    clear_inputs();
    bi.id_branch = 1; bi.id_rs = 8;
    cycle("wrap.res");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bi.id_branch    = $urandom_range(0, 1);
      bi.id_uses_rt   = $urandom_range(0, 1);
      bi.id_rs        = 5'($urandom_range(0, 7));
      bi.id_rt        = 5'($urandom_range(0, 7));
      bi.id_target    = $urandom;
      bi.ex_regwrite  = $urandom_range(0, 1);
      bi.ex_memtoreg  = $urandom_range(0, 1);
      bi.ex_writereg  = 5'($urandom_range(0, 7));
      bi.mem_regwrite = $urandom_range(0, 1);
      bi.mem_memtoreg = $urandom_range(0, 1);
      bi.mem_writereg = 5'($urandom_range(0, 7));
      bi.flush        = ($urandom_range(0, 15) == 0);
      bi.cmp_taken    = $urandom_range(0, 1);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
